// File: rtl/result_stream_drain_if.sv
// Bundle of the result-capture inputs and the outgoing beat stream of
// result_stream_drain. The master modport is the drain block itself; the slave
// modport is the producer/sink side that feeds results and consumes beats.
interface result_stream_drain_if #(
  parameter int SIZE       = 4,
  parameter int DATA_WIDTH = 4,
  parameter int OUT_WIDTH  = 32
);
  logic [SIZE*SIZE*2*DATA_WIDTH-1:0] result_matrix;
  logic                              result_valid;
  logic [OUT_WIDTH-1:0]              m_tdata;
  logic                              m_tvalid;
  logic                              m_tready;
  logic                              m_tlast;
  logic                              busy;
  logic                              drain_done;

  modport master (
    input  result_matrix, result_valid, m_tready,
    output m_tdata, m_tvalid, m_tlast, busy, drain_done
  );

  modport slave (
    output result_matrix, result_valid, m_tready,
    input  m_tdata, m_tvalid, m_tlast, busy, drain_done
  );
endinterface

// File: rtl/result_stream_drain.sv
// result_stream_drain: snapshots a SIZE x SIZE result matrix on a rising
// result_valid and streams it out as ceil(SIZE*SIZE/EPB) beats, EPB elements
// per beat, lowest element in the LSBs, unused tail slots zero.
// Optional build macro RESULT_DRAIN_FRAME_CNT_EN adds a 16-bit frame_count
// output that counts completed frames (wraps at 0xFFFF).
module result_stream_drain #(
  parameter int SIZE       = 4,
  parameter int DATA_WIDTH = 4,
  parameter int OUT_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  result_stream_drain_if.master        bus
`ifdef RESULT_DRAIN_FRAME_CNT_EN
  ,
  output logic [15:0]                  frame_count
`endif
);

  localparam int ELEM_W = 2 * DATA_WIDTH;
  localparam int MAT_W  = SIZE * SIZE * ELEM_W;
  localparam int EPB    = OUT_WIDTH / ELEM_W;
  localparam int NB     = (SIZE * SIZE + EPB - 1) / EPB;
  localparam int PAD_W  = NB * OUT_WIDTH;
  localparam int BW     = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             armed_q, armed_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [PAD_W-1:0] frame_q, frame_d;
  logic [PAD_W-1:0] frame_pad;
  logic             capture;
  logic             last_beat;

  // Zero-extend the matrix to a whole number of beats so tail slots read as 0.
  always_comb begin
    frame_pad              = '0;
    frame_pad[MAT_W-1:0]   = bus.result_matrix;
  end

  assign capture   = (state_q == IDLE) && bus.result_valid && armed_q;
  assign last_beat = (beat_q == LAST_BEAT);

  // Next-state logic: capture on an armed rising valid, advance on accepted beats.
  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    beat_d  = beat_q;
    frame_d = frame_q;
    // Any low cycle of result_valid re-arms capture, even mid-frame.
    if (!bus.result_valid) begin
      armed_d = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (capture) begin
          frame_d = frame_pad;
          beat_d  = '0;
          armed_d = 1'b0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (bus.m_tready) begin
          if (last_beat) begin
            state_d = FINISH;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      armed_q <= 1'b1;
      beat_q  <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      beat_q  <= beat_d;
      frame_q <= frame_d;
    end
  end

  // Stream outputs decode straight from held state, so they stay stable under backpressure.
  always_comb begin
    bus.m_tvalid   = (state_q == STREAM);
    bus.m_tlast    = (state_q == STREAM) && last_beat;
    bus.m_tdata    = '0;
    if (state_q == STREAM) begin
      bus.m_tdata  = frame_q[int'(beat_q) * OUT_WIDTH +: OUT_WIDTH];
    end
    bus.busy       = (state_q != IDLE);
    bus.drain_done = (state_q == FINISH);
  end

`ifdef RESULT_DRAIN_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Count every drain_done pulse; natural 16-bit wrap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_cnt_q <= '0;
    end else if (state_q == FINISH) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_count = frame_cnt_q;
`endif

endmodule

// File: tb/tb_result_stream_drain.sv
// Scoreboard bench for result_stream_drain: a 4x4 instance and a 3x3 instance
// (partial last beat) share stimulus; a frame-level model pushes expected beats
// on predicted captures and a negedge monitor pops and compares them.
module tb_result_stream_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic        rv;
  logic        rdy;
  logic [7:0]  elem [16];
  logic [127:0] mat;

  int nchk = 0;
  int nerr = 0;
  int dd_cnt = 0;
  bit started = 1'b0;
  bit rst_seen = 1'b0;

  always #5 clk = ~clk;

  result_stream_drain_if #(.SIZE(4), .DATA_WIDTH(4), .OUT_WIDTH(32)) if0 ();
  result_stream_drain_if #(.SIZE(3), .DATA_WIDTH(4), .OUT_WIDTH(32)) if1 ();

`ifdef RESULT_DRAIN_FRAME_CNT_EN
  logic [15:0] fcnt0, fcnt1;
  result_stream_drain #(.SIZE(4), .DATA_WIDTH(4), .OUT_WIDTH(32)) dut0 (
    .clk(clk), .rst(rst), .bus(if0.master), .frame_count(fcnt0));
  result_stream_drain #(.SIZE(3), .DATA_WIDTH(4), .OUT_WIDTH(32)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.master), .frame_count(fcnt1));
`else
  result_stream_drain #(.SIZE(4), .DATA_WIDTH(4), .OUT_WIDTH(32)) dut0 (
    .clk(clk), .rst(rst), .bus(if0.master));
  result_stream_drain #(.SIZE(3), .DATA_WIDTH(4), .OUT_WIDTH(32)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.master));
`endif

  // Pack element k at byte k.
  always_comb begin
    for (int k = 0; k < 16; k++) mat[k*8 +: 8] = elem[k];
  end

  assign if0.result_matrix = mat;
  assign if1.result_matrix = mat[71:0];
  assign if0.result_valid  = rv;
  assign if1.result_valid  = rv;
  assign if0.m_tready      = rdy;
  assign if1.m_tready      = rdy;

  logic [31:0] td [2];
  logic        tv [2], tl [2], bz [2], dn [2];
  assign td[0] = if0.m_tdata;  assign td[1] = if1.m_tdata;
  assign tv[0] = if0.m_tvalid; assign tv[1] = if1.m_tvalid;
  assign tl[0] = if0.m_tlast;  assign tl[1] = if1.m_tlast;
  assign bz[0] = if0.busy;     assign bz[1] = if1.busy;
  assign dn[0] = if0.drain_done; assign dn[1] = if1.drain_done;

  // Expected beats {last, data}, one queue per instance.
  logic [32:0] q0 [$];
  logic [32:0] q1 [$];

  function automatic void qpush(int i, logic [32:0] v);
    if (i == 0) q0.push_back(v); else q1.push_back(v);
  endfunction
  function automatic int qsize(int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction
  function automatic logic [32:0] qfront(int i);
    return (i == 0) ? q0[0] : q1[0];
  endfunction
  function automatic void qpop(int i);
    if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
  endfunction
  function automatic void qclear(int i);
    if (i == 0) q0.delete(); else q1.delete();
  endfunction

  // Beat b of a frame with n_el elements: 4 bytes, lowest element first, zeros past the end.
  function automatic logic [31:0] beat_val(int n_el, int b);
    logic [31:0] v;
    v = '0;
    for (int j = 0; j < 4; j++) begin
      if (b * 4 + j < n_el) v[8*j +: 8] = elem[b * 4 + j];
    end
    return v;
  endfunction

  task automatic chk(int i, string name, logic [63:0] act, logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL inst%0d %s: got %0h expected %0h at %0t", i, name, act, exp, $time);
    end
  endtask

  // Frame-level reference: 0 idle, 1 streaming with beats remaining, 2 finish cycle.
  int mst [2];
  int rem [2];
  bit armed [2];
  int fc0;
  int nb  [2] = '{4, 3};
  int nel [2] = '{16, 9};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        mst[i] = 0; rem[i] = 0; armed[i] = 1'b1; qclear(i);
        if (i == 0) fc0 = 0;
      end else begin
        case (mst[i])
          0: begin
            if (rv && armed[i]) begin
              for (int b = 0; b < nb[i]; b++)
                qpush(i, {(b == nb[i] - 1), beat_val(nel[i], b)});
              rem[i] = nb[i]; mst[i] = 1; armed[i] = 1'b0;
            end else if (!rv) armed[i] = 1'b1;
          end
          1: begin
            if (!rv) armed[i] = 1'b1;
            if (rdy) begin
              rem[i]--;
              if (rem[i] == 0) mst[i] = 2;
            end
          end
          default: begin
            if (!rv) armed[i] = 1'b1;
            mst[i] = 0;
            if (i == 0) fc0 = (fc0 + 1) % 65536;
          end
        endcase
      end
    end
    rst_seen = !rst;
    started  = 1'b1;
  end

  // Monitor: compare handshake/status each cycle and presented beats against the scoreboard.
  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        chk(i, "m_tvalid", 64'(tv[i]), 64'(mst[i] == 1));
        chk(i, "busy", 64'(bz[i]), 64'(mst[i] != 0));
        chk(i, "drain_done", 64'(dn[i]), 64'(mst[i] == 2));
        if (rst_seen) chk(i, "reset_tdata", 64'(td[i]), 64'd0);
        if (!tv[i]) chk(i, "m_tlast_idle", 64'(tl[i]), 64'd0);
        if (tv[i]) begin
          chk(i, "beat_expected", 64'(qsize(i) > 0), 64'd1);
          if (qsize(i) > 0) begin
            chk(i, "m_tdata", 64'(td[i]), 64'(qfront(i) & 33'h0_FFFF_FFFF));
            chk(i, "m_tlast", 64'(tl[i]), 64'(qfront(i) >> 32));
            if (rdy) qpop(i);
          end
        end
      end
      if (dn[0]) dd_cnt++;
`ifdef RESULT_DRAIN_FRAME_CNT_EN
      chk(0, "frame_count", 64'(fcnt0), 64'(fc0));
`endif
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rand_elems();
    for (int k = 0; k < 16; k++) elem[k] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    rst = 1'b0; rv = 1'b0; rdy = 1'b1;
    for (int k = 0; k < 16; k++) elem[k] = 8'h00;
    cyc(3);
    rst = 1'b1;

    // Basic frame, valid held high 20 cycles: one frame, one drain_done.
    for (int k = 0; k < 16; k++) elem[k] = 8'(k + 1);
    dd_cnt = 0;
    rv = 1'b1;
    cyc(20);
    chk(0, "one_done_per_held_valid", 64'(dd_cnt), 64'd1);

    // Backpressure on beat 2 for three cycles.
    rv = 1'b0; cyc(1);
    rv = 1'b1; cyc(1);
    cyc(1);
    rdy = 1'b0; cyc(3);
    rdy = 1'b1; cyc(8);

    // Retrigger while idle with new data.
    rv = 1'b0; cyc(1);
    rand_elems();
    rv = 1'b1; cyc(10);

    // Reset mid-frame, then a fresh rise streams from beat 0.
    rv = 1'b0; cyc(1);
    rv = 1'b1; cyc(3);
    rst = 1'b0; cyc(1);
    rst = 1'b1; rv = 1'b0; cyc(1);
    rand_elems();
    rv = 1'b1; cyc(8);

    // Re-arm during a frame: new data captured in the first idle cycle.
    rv = 1'b0; cyc(1);
    rv = 1'b1; cyc(2);
    rv = 1'b0; cyc(1);
    rand_elems();
    rv = 1'b1; cyc(12);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 500; n++) begin
      rv  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 3) == 0) rand_elems();
      cyc(1);
    end

    // Drain.
    rst = 1'b1; rv = 1'b0; rdy = 1'b1;
    cyc(12);
    for (int i = 0; i < 2; i++) chk(i, "scoreboard_empty", 64'(qsize(i)), 64'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
